// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//   Turns the asynchronous PLL LOCK flag into a clean, registered active-low
//   system reset for the processor clock domain.
//
//   Operation:
//     - LOCK is synchronised.
//     - It must then stay high for LOCK_STABLE_CYCLES consecutive cycles.
//     - Reset is then held for RESET_HOLD_CYCLES more cycles and released.
//     - Losing lock after release re-asserts reset and bumps a saturating
//       loss counter.
//     - A software request re-runs only the hold interval.
//
//   Ports:
//     clock_in         in   1  system clock (PLL-derived), posedge
//     reset_n          in   1  asynchronous active-low reset
//     pll_lock         in   1  PLL LOCK, asynchronous to clock_in
//     sw_reset_req     in   1  single-cycle request to re-run the reset hold
//     sys_reset_n      out  1  active-low downstream reset, registered
//     sys_ready        out  1  high one cycle after sys_reset_n rises
//     lock_loss_count  out  8  lock losses seen in RUN, saturating at 255
//     seq_state        out  2  current sequencer state (debug)
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned CNT_W              = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       sw_reset_req,
    output logic       sys_reset_n,
    output logic       sys_ready,
    output logic [7:0] lock_loss_count,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Terminal counts for the two timed intervals
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       LOSS_MAX  = 8'hFF;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_lock_s;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   w_loss_inc;
    logic                   w_next_run;

    // LOCK synchroniser; only the last stage is visible to the sequencer
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Next-state and interval counter
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_loss_inc   = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next_state = ST_STABILIZE;
                    w_next_cnt   = '0;
                end
            end
            ST_STABILIZE: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_cnt == LOCK_LAST) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_cnt == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                // Lock loss wins over a coincident software request
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_loss_inc   = 1'b1;
                end else if (sw_reset_req) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign w_next_run = (w_next_state == ST_RUN);

    // State register and registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= '0;
            sys_reset_n     <= 1'b0;
            sys_ready       <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            // Reset follows the next state so it moves on the same edge as the FSM
            sys_reset_n <= w_next_run;
            // Ready lags the release by one cycle but drops together with reset
            sys_ready   <= w_next_run & sys_reset_n & (r_state == ST_RUN);
            if (w_loss_inc && (lock_loss_count != LOSS_MAX)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

    assign seq_state = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

    logic       clock_in;
    logic       reset_n;
    logic       pll_lock;
    logic       sw_reset_req;
    logic       sys_reset_n;
    logic       sys_ready;
    logic [7:0] lock_loss_count;
    logic [1:0] seq_state;

    int n_checks;
    int n_errors;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES (4),
        .CNT_W             (16)
    ) dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .pll_lock       (pll_lock),
        .sw_reset_req   (sw_reset_req),
        .sys_reset_n    (sys_reset_n),
        .sys_ready      (sys_ready),
        .lock_loss_count(lock_loss_count),
        .seq_state      (seq_state)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle just past the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic rn, input logic rdy,
                           input logic [7:0] cnt, input logic [1:0] st);
        chk({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(rn));
        chk({tag, ".sys_ready"}, 32'(sys_ready), 32'(rdy));
        chk({tag, ".count"}, 32'(lock_loss_count), 32'(cnt));
        chk({tag, ".state"}, 32'(seq_state), 32'(st));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b1;
        pll_lock     = 1'b0;
        sw_reset_req = 1'b0;

        // 1: asynchronous reset mid-clock, no edge required
        #2 reset_n = 1'b0;
        #1;
        chk_all("reset_async", 1'b0, 1'b0, 8'd0, 2'd0);
        tick(1);
        chk_all("reset_held", 1'b0, 1'b0, 8'd0, 2'd0);

        // 2: clean start, lock rises before edge 1
        reset_n  = 1'b1;
        pll_lock = 1'b1;
        tick(2);
        chk("start.e2_state", 32'(seq_state), 32'd0);
        tick(1);
        chk("start.e3_state", 32'(seq_state), 32'd1);
        tick(8);
        chk("start.e11_state", 32'(seq_state), 32'd2);
        tick(3);
        chk_all("start.e14", 1'b0, 1'b0, 8'd0, 2'd2);
        tick(1);
        chk_all("start.e15", 1'b1, 1'b0, 8'd0, 2'd3);
        tick(1);
        chk_all("start.e16", 1'b1, 1'b1, 8'd0, 2'd3);

        // 4: loss of lock in RUN, reset falls on the 3rd edge
        pll_lock = 1'b0;
        tick(2);
        chk_all("loss.e2", 1'b1, 1'b1, 8'd0, 2'd3);
        tick(1);
        chk_all("loss.e3", 1'b0, 1'b0, 8'd1, 2'd0);
        pll_lock = 1'b1;
        tick(14);
        chk("relock.e14_rst", 32'(sys_reset_n), 32'd0);
        tick(1);
        chk_all("relock.e15", 1'b1, 1'b0, 8'd1, 2'd3);
        tick(1);
        chk("relock.e16_ready", 32'(sys_ready), 32'd1);

        // 5a: software request re-runs the hold; held high across HOLD too
        sw_reset_req = 1'b1;
        tick(1);
        chk_all("sw.e1", 1'b0, 1'b0, 8'd1, 2'd2);
        tick(1);
        sw_reset_req = 1'b0;
        chk("sw.e2_rst", 32'(sys_reset_n), 32'd0);
        tick(2);
        chk("sw.e4_rst", 32'(sys_reset_n), 32'd0);
        tick(1);
        chk_all("sw.e5", 1'b1, 1'b0, 8'd1, 2'd3);
        tick(1);
        chk("sw.e6_ready", 32'(sys_ready), 32'd1);

        // 5b: request coincides with synced lock falling -> loss wins
        pll_lock = 1'b0;
        tick(2);
        sw_reset_req = 1'b1;
        chk("swloss.e2_rst", 32'(sys_reset_n), 32'd1);
        tick(1);
        sw_reset_req = 1'b0;
        chk_all("swloss.e3", 1'b0, 1'b0, 8'd2, 2'd0);

        // 3: one-cycle glitch during STABILIZE restarts the whole sequence
        pll_lock = 1'b1;
        tick(5);
        chk("glitch.e5_state", 32'(seq_state), 32'd1);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(2);
        chk_all("glitch.e8", 1'b0, 1'b0, 8'd2, 2'd0);
        tick(1);
        chk("glitch.e9_state", 32'(seq_state), 32'd1);
        tick(11);
        chk("glitch.e20_rst", 32'(sys_reset_n), 32'd0);
        tick(1);
        chk_all("glitch.e21", 1'b1, 1'b0, 8'd2, 2'd3);

        // 6: repeated losses up to and past saturation
        for (int i = 0; i < 252; i++) begin
            pll_lock = 1'b0;
            tick(3);
            pll_lock = 1'b1;
            tick(15);
        end
        chk("sat.254", 32'(lock_loss_count), 32'd254);
        for (int i = 0; i < 6; i++) begin
            pll_lock = 1'b0;
            tick(3);
            pll_lock = 1'b1;
            tick(15);
        end
        chk_all("sat.255", 1'b1, 1'b0, 8'd255, 2'd3);

        // 6: async reset in the middle of HOLD clears everything
        pll_lock = 1'b0;
        tick(3);
        chk_all("sat.loss", 1'b0, 1'b0, 8'd255, 2'd0);
        pll_lock = 1'b1;
        tick(12);
        chk("hold.state", 32'(seq_state), 32'd2);
        #3 reset_n = 1'b0;
        #1;
        chk_all("hold.reset", 1'b0, 1'b0, 8'd0, 2'd0);
        tick(2);
        chk_all("hold.reset_held", 1'b0, 1'b0, 8'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
